// File: rtl/dualport_ram_be.sv
// dualport_ram_be
//   True dual-port synchronous RAM with per-byte write enables, selectable
//   same-port read-during-write behaviour, same-address collision flag and a
//   built-in clear sequencer that zeroes the whole array after every reset.
//
//   Ports (port 1 shown, port 2 identical):
//     clk, rst      : clock, synchronous active-high reset
//     en1, we1      : access request, write qualifier
//     be1           : byte enables, bit i covers datain1[8i+7:8i]
//     addr1         : word address
//     datain1       : write data
//     dout1, valid1 : registered read data and its one-cycle valid pulse
//     busy          : clear sweep in progress, all requests dropped
//     collision     : previous cycle had a same-address access with a write
module dualport_ram_be #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = 0,
  parameter int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              we1,
  input  logic [BE_W-1:0]   be1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] datain1,
  output logic [DATA_W-1:0] dout1,
  output logic              valid1,
  input  logic              en2,
  input  logic              we2,
  input  logic [BE_W-1:0]   be2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] datain2,
  output logic [DATA_W-1:0] dout2,
  output logic              valid2,
  output logic              busy,
  output logic              collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_N  = BE_W;

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   dout1_q, dout1_d, dout2_q, dout2_d;
  logic                valid1_q, valid1_d, valid2_q, valid2_d;
  logic                collision_q, collision_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc1, acc2, wr1, wr2, same_addr;
  logic [DATA_W-1:0]   old1, old2, merged1, merged2, wword2;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < BE_N; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == '1) state_d = READY;
    end

    acc1      = en1 && (state_q == READY);
    acc2      = en2 && (state_q == READY);
    wr1       = acc1 && we1;
    wr2       = acc2 && we2;
    same_addr = (addr1 == addr2);

    old1    = mem[addr1];
    old2    = mem[addr2];
    merged1 = merge(old1, datain1, be1);
    merged2 = merge(old2, datain2, be2);
    // Dual write to one word: port 1 bytes are layered over port 2's merge,
    // so a single array write carries the combined result.
    wword2  = (wr1 && same_addr) ? merge(merged2, datain1, be1) : merged2;

    dout1_d = dout1_q;
    dout2_d = dout2_q;
    if (acc1) dout1_d = (wr1 && RD_MODE != 0) ? merged1 : old1;
    if (acc2) dout2_d = (wr2 && RD_MODE != 0) ? merged2 : old2;
    valid1_d    = acc1;
    valid2_d    = acc2;
    collision_d = acc1 && acc2 && same_addr && (we1 || we2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      dout1_q     <= '0;
      dout2_q     <= '0;
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
      valid1_q    <= valid1_d;
      valid2_q    <= valid2_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_addr_q] <= '0;
      end else begin
        if (wr2) mem[addr2] <= wword2;
        if (wr1 && !(wr2 && same_addr)) mem[addr1] <= merged1;
      end
    end
  end

  assign dout1     = dout1_q;
  assign dout2     = dout2_q;
  assign valid1    = valid1_q;
  assign valid2    = valid2_q;
  assign collision = collision_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: doc/dualport_ram_be.md
# dualport_ram_be

Parametrised true dual-port synchronous RAM, the next generation of the team's fixed 8-bit x 64 dual-port RAM. Width and depth are configurable, both ports have byte-write enables and read-enable qualification, read-during-write behaviour is selectable, and same-address collisions are flagged. A built-in clear sequencer zeroes the array after every reset, so downstream logic never reads uninitialised storage. It sits between two independent masters that share a single clock domain.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 6: address width; depth = 2**ADDR_W words.
- RD_MODE, 0: same-port read-during-write. 0 = read-first (old data), 1 = write-first (new data).
- BE_W, DATA_W/8: byte-enable width. Derived; do not override.

- clk  in  1  clock; all logic rises on the posedge.
- rst  in  1  synchronous reset, active-high.
- en1  in  1  port 1 access request.
- we1  in  1  port 1 write (qualified by en1).
- be1  in  BE_W  port 1 byte enables; bit i covers din1[8i+7:8i].
- addr1  in  ADDR_W  port 1 address.
- datain1  in  DATA_W  port 1 write data.
- dout1  out  DATA_W  port 1 registered read data.
- valid1  out  1  dout1 updated this cycle.
- en2, we2, be2, addr2, datain2, dout2, valid2: port 2, identical to port 1.
- busy  out  1  clear sequencer active; all requests ignored.
- collision  out  1  registered flag for a same-address conflict in the previous cycle.

## Operation
- Access: a port issues an access when enX=1 and busy=0. With weX=1, each byte i with beX[i]=1 is written and bytes with beX[i]=0 keep their contents. Every accepted access also performs a read and updates doutX.
- Read data:
  - With weX=0, doutX returns the stored word.
  - With weX=1, RD_MODE=0 returns the word before the write; RD_MODE=1 returns the merged post-write word.
- Cross-port read of an address written by the other port in the same cycle always returns the old data, regardless of RD_MODE.
- Dual write to the same address: bytes enabled on both ports take port 1's data. Bytes enabled on only one port take that port's data.
- collision: set to 1 for one cycle when both ports were accepted at the same address and at least one had we=1. Otherwise 0.
- Clear FSM, states CLEAR and READY:
  - While rst=1: state=CLEAR, clr_addr=0, no array writes.
  - In CLEAR with rst=0: write 0 to clr_addr, then increment it. When clr_addr=2**ADDR_W-1 is written, go to READY.
  - READY holds until the next rst.
  - busy = (state==CLEAR).
- Reset mid-clear, or asserted at any time: restarts the sweep at address 0.
- Requests during busy are dropped. No queuing, no valid, no collision.
- Addresses are full ADDR_W decode; no out-of-range case exists.

## Timing
- Reset values (the cycle after rst is sampled high): dout1=dout2=0, valid1=valid2=0, collision=0, busy=1.
- Clear duration: busy stays 1 for exactly 2**ADDR_W cycles after the first cycle rst is sampled low. With the defaults, the first access is accepted 64 cycles after reset release.
- Read latency: 1 cycle. An access sampled at edge N drives doutX and validX=1 after edge N.
- valid is a single-cycle pulse per access; back-to-back accesses hold it at 1.
- When no access is accepted, doutX holds its last value and validX=0.
- Write latency: data written at edge N is visible to a read from either port sampled at edge N+1.
- collision shares the read latency: it asserts in the same cycle as the valid flags of the conflicting accesses.

## Test plan
- Clear after reset: pulse rst for 2 cycles, then hold en1=1, we1=0 and sweep every address as soon as busy falls. Required: busy high for exactly 64 cycles, every dout1=0x00, valid1 one cycle after each accepted request.
- Basic dual write/read: write 0x33 to addr 1 on port 1 and 0x44 to addr 2 on port 2; next cycle read addr 2 on port 1 and addr 1 on port 2. Required: dout1=0x44, dout2=0x33, collision=0.
- Byte enables (DATA_W=16): write 0xAABB to addr 5 with be=2'b11, then 0x1234 with be=2'b01. Required: a read returns 0xAA34.
- Read-during-write: addr 3 holds 0x55; port 1 writes 0x77 to addr 3 while port 2 reads addr 3. Required: RD_MODE=0 gives dout1=0x55; RD_MODE=1 gives dout1=0x77; dout2=0x55 in both modes; collision=1 for one cycle.
- Dual-write conflict: both ports write addr 7, port 1 0x11 and port 2 0x22, full byte enables. Required: collision=1, and a subsequent read returns 0x11.
- Reset mid-clear: assert rst at clear cycle 30, release it, and attempt a write during busy. Required: busy stays high for another full 64 cycles, the write is dropped (valid=0), and memory reads 0x00.
